// File: rtl/ctrl_suma_nibbles.sv
// -----------------------------------------------------------------------------
// ctrl_suma_nibbles
//
// Purpose:
//   Sequencer that adds two W-bit operands (W = 4*NIB) through one shared,
//   purely combinational 4-bit adder (suma4bits). One nibble is processed per
//   clock, least significant first, and the carry is chained between nibbles.
//   A start/busy/done handshake faces the lab top level.
//
// Parameters:
//   NIB       number of nibbles per operand (2..8); W = 4*NIB.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous reset, active low
//   start     request a new addition (honoured only in IDLE or DONE)
//   A, B      operands, latched when start is accepted
//   Cin       initial carry, latched when start is accepted
//   nib_a     to adder A: current nibble of the latched A (0 outside RUN)
//   nib_b     to adder B: current nibble of the latched B (0 outside RUN)
//   nib_cin   to adder Cin: running carry (0 outside RUN)
//   nib_s     from adder S (combinational)
//   nib_cout  from adder Cout (combinational)
//   busy      high while the addition is running
//   done      one-cycle pulse when S/Cout have been updated
//   S, Cout   registered result; holds the last completed addition
//   ovf       (only with SUMA_OVF_EN) registered two's-complement overflow
//
// Optional feature:
//   Define SUMA_OVF_EN to add the ovf output and its overflow detection.
// -----------------------------------------------------------------------------
module ctrl_suma_nibbles #(
    parameter int NIB = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4*NIB-1:0] A,
    input  logic [4*NIB-1:0] B,
    input  logic             Cin,
    output logic [3:0]       nib_a,
    output logic [3:0]       nib_b,
    output logic             nib_cin,
    input  logic [3:0]       nib_s,
    input  logic             nib_cout,
    output logic             busy,
    output logic             done,
    output logic [4*NIB-1:0] S,
    output logic             Cout
`ifdef SUMA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int W    = 4 * NIB;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [IDXW-1:0]   idx_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [W-1:0]      partial_q;
    logic              carry_q;
    logic [3:0]        nib_a_q;
    logic [3:0]        nib_b_q;
    logic              busy_q;
    logic              done_q;
    logic [W-1:0]      s_q;
    logic              cout_q;
`ifdef SUMA_OVF_EN
    logic              ovf_q;
`endif

    logic [W-1:0]      merged_d;
    logic              last_d;
    logic [IDXW-1:0]   idx_d;
    logic [3:0]        next_a_d;
    logic [3:0]        next_b_d;

    // Partial sum with the current adder nibble merged in, and the operand
    // nibbles to present in the following RUN cycle.
    always_comb begin
        merged_d                 = partial_q;
        merged_d[4*idx_q +: 4]   = nib_s;
        last_d                   = (idx_q == IDXW'(NIB - 1));
        idx_d                    = idx_q + IDXW'(1);
        if (last_d) begin
            // No further nibble: the adder inputs return to zero in DONE.
            next_a_d = 4'd0;
            next_b_d = 4'd0;
        end else begin
            next_a_d = a_q[4*idx_d +: 4];
            next_b_d = b_q[4*idx_d +: 4];
        end
    end

    // Control FSM with all outputs registered. The carry register doubles as
    // the adder's carry input, so it is cleared whenever RUN is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            partial_q <= '0;
            carry_q   <= 1'b0;
            nib_a_q   <= 4'd0;
            nib_b_q   <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            s_q       <= '0;
            cout_q    <= 1'b0;
`ifdef SUMA_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_q       <= A;
                        b_q       <= B;
                        carry_q   <= Cin;
                        idx_q     <= '0;
                        partial_q <= '0;
                        nib_a_q   <= A[3:0];
                        nib_b_q   <= B[3:0];
                        busy_q    <= 1'b1;
                        state_q   <= ST_RUN;
                    end else begin
                        state_q   <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    partial_q <= merged_d;
                    idx_q     <= idx_d;
                    nib_a_q   <= next_a_d;
                    nib_b_q   <= next_b_d;
                    if (last_d) begin
                        s_q     <= merged_d;
                        cout_q  <= nib_cout;
                        carry_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
`ifdef SUMA_OVF_EN
                        // Same-sign operands whose sum sign differs.
                        ovf_q   <= (a_q[W-1] == b_q[W-1]) && (nib_s[3] != a_q[W-1]);
`endif
                    end else begin
                        carry_q <= nib_cout;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                    carry_q <= 1'b0;
                    nib_a_q <= 4'd0;
                    nib_b_q <= 4'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign nib_a   = nib_a_q;
    assign nib_b   = nib_b_q;
    assign nib_cin = carry_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign S       = s_q;
    assign Cout    = cout_q;
`ifdef SUMA_OVF_EN
    assign ovf     = ovf_q;
`endif

endmodule
